alif_spike_event_logger: RTL and testbench

- Downstream stage of the dual-channel ALIF neuron system; consumes its spike output.
- Timestamps each spike with a free-running cycle counter and buffers the timestamps in a small FIFO.
- Drains buffered timestamps MSB-first as serial frames under a ready/valid handshake, so off-chip logic can read spike timing over a single output pin.
- Also keeps a saturating spike count and a sticky overflow flag.

---
 rtl/alif_spike_event_logger_if.sv | 21 ++
 rtl/alif_spike_event_logger.sv | 124 ++++++++++++
 tb/tb_alif_spike_event_logger.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alif_spike_event_logger_if.sv
// Serial timestamp stream: one bit per accepted handshake, MSB first.
interface alif_spike_event_logger_if;
  logic out_ready;
  logic out_valid;
  logic out_bit;
  logic out_frame_start;

  modport master (
    input  out_ready,
    output out_valid,
    output out_bit,
    output out_frame_start
  );

  modport slave (
    output out_ready,
    input  out_valid,
    input  out_bit,
    input  out_frame_start
  );
endinterface

// File: rtl/alif_spike_event_logger.sv
// Spike event logger: timestamps rising edges of spike_in, buffers them in a
// small FIFO and drains each timestamp as an MSB-first serial frame.
module alif_spike_event_logger #(
  parameter int unsigned TS_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        spike_in,
  input  logic                        clear_ovf,
  alif_spike_event_logger_if.master   ser,
  output logic [ADDR_W:0]             fifo_level,
  output logic [7:0]                  spike_count,
  output logic                        ovf_flag
);

  localparam int unsigned CntW = (TS_WIDTH > 1) ? $clog2(TS_WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  logic [TS_WIDTH-1:0] ts_q;
  logic                spike_prev_q;
  logic [TS_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     level_q, level_d;
  state_e              state_q, state_d;
  logic [TS_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]          spike_count_q;
  logic                ovf_q;

  logic event_det, full, push, pop, valid, frame_start;

  assign event_det = spike_in & ~spike_prev_q;
  assign full      = (level_q == (ADDR_W + 1)'(FIFO_DEPTH));
  // A full FIFO still accepts the event when the head leaves on the same edge.
  assign push      = event_det & (~full | pop);
  assign level_d   = level_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);

  // Serializer next state, pop request and stream outputs.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    pop         = 1'b0;
    valid       = 1'b0;
    frame_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (level_q != '0) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        valid       = 1'b1;
        frame_start = (bit_cnt_q == '0);
        if (ser.out_ready) begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CntW'(TS_WIDTH - 1)) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Timestamp counter, spike edge detector, FIFO pointers and serializer state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q         <= '0;
      spike_prev_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
    end else if (enable) begin
      ts_q         <= ts_q + 1'b1;
      spike_prev_q <= spike_in;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q      <= level_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
    end
  end

  // Saturating spike counter and sticky overflow; a drop beats a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spike_count_q <= '0;
      ovf_q         <= 1'b0;
    end else if (enable) begin
      if (event_det && spike_count_q != 8'hFF) spike_count_q <= spike_count_q + 1'b1;
      if (event_det && !push) begin
        ovf_q <= 1'b1;
      end else if (clear_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (enable && push) mem_q[wr_ptr_q] <= ts_q;
  end

  assign ser.out_valid       = valid;
  assign ser.out_bit         = valid & shift_q[TS_WIDTH-1];
  assign ser.out_frame_start = frame_start;
  assign fifo_level          = level_q;
  assign spike_count         = spike_count_q;
  assign ovf_flag            = ovf_q;

endmodule

// File: tb/tb_alif_spike_event_logger.sv
// Bench for alif_spike_event_logger: queue-based reference model checked every
// cycle, plus literal expectations on delivered frames and status.
module tb_alif_spike_event_logger;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       spk = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] level;
  logic [7:0] count;
  logic       ovf;

  int tests = 0;
  int fails = 0;

  alif_spike_event_logger_if ser_if ();

  alif_spike_event_logger #(
    .TS_WIDTH  (8),
    .FIFO_DEPTH(4),
    .ADDR_W    (2)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .enable     (en),
    .spike_in   (spk),
    .clear_ovf  (clr),
    .ser        (ser_if.master),
    .fifo_level (level),
    .spike_count(count),
    .ovf_flag   (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Reference model: timestamps of events queued, one frame in flight.
  int         m_ts, m_cnt, m_idx;
  logic       m_prev, m_ovf, m_busy, m_ev;
  logic [7:0] m_word;
  logic [7:0] m_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ts = 0; m_cnt = 0; m_idx = 0; m_prev = 0; m_ovf = 0; m_busy = 0; m_word = 0;
      m_q.delete();
    end else if (en) begin
      if (m_busy) begin
        if (ser_if.out_ready) begin
          m_idx++;
          if (m_idx == 8) m_busy = 0;
        end
      end else if (m_q.size() > 0) begin
        m_word = m_q.pop_front();
        m_idx  = 0;
        m_busy = 1;
      end
      m_ev = spk && !m_prev;
      if (m_ev && m_cnt < 255) m_cnt++;
      if (m_ev && m_q.size() < 4) m_q.push_back(8'(m_ts));
      if (m_ev && m_q.size() >= 4 && !(m_q.size() == 4 && m_q[3] == 8'(m_ts))) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_ts   = (m_ts + 1) % 256;
      m_prev = spk;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  int m_bit;
  always @(negedge clk) begin
    if (rst_n) begin
      m_bit = (m_busy && m_word[7-m_idx]) ? 1 : 0;
      chk("out_valid", int'(ser_if.out_valid), int'(m_busy));
      chk("out_bit", int'(ser_if.out_bit), m_bit);
      chk("out_frame_start", int'(ser_if.out_frame_start), (m_busy && m_idx == 0) ? 1 : 0);
      chk("fifo_level", int'(level), m_q.size());
      chk("spike_count", int'(count), m_cnt);
      chk("ovf_flag", int'(ovf), int'(m_ovf));
    end
  end

  // Frame collector: a bit counts when it is valid, ready and enabled at the edge.
  logic [7:0] frames[$];
  logic [7:0] cur;
  int         nbits = 0;
  int         vcycles = 0;
  always @(negedge clk) begin
    if (rst_n && ser_if.out_valid) vcycles++;
    if (rst_n && en && ser_if.out_valid && ser_if.out_ready) begin
      if (ser_if.out_frame_start) nbits = 0;
      cur = {cur[6:0], ser_if.out_bit};
      nbits++;
      if (nbits == 8) begin
        frames.push_back(cur);
        nbits = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 0; en = 1; spk = 0; clr = 0; ser_if.out_ready = 1;
    ticks(2);
    chk("reset out_valid", int'(ser_if.out_valid), 0);
    chk("reset fifo_level", int'(level), 0);
    chk("reset spike_count", int'(count), 0);
    chk("reset ovf_flag", int'(ovf), 0);
    rst_n = 1;
    frames.delete();
    vcycles = 0;
    nbits = 0;
  endtask

  task automatic pulse();
    spk = 1; tick(); spk = 0;
  endtask

  task automatic chk_frames(input string name, input logic [7:0] exp[$]);
    chk({name, " frame count"}, frames.size(), exp.size());
    for (int i = 0; i < exp.size() && i < frames.size(); i++)
      chk({name, " frame value"}, int'(frames[i]), int'(exp[i]));
  endtask

  task automatic wait_ts(input int v);
    int n = 0;
    while (m_ts != v && n < 300) begin tick(); n++; end
    chk("wait for timestamp", m_ts, v);
  endtask

  task automatic wait_valid(input int lim);
    int n = 0;
    while (!ser_if.out_valid && n < lim) begin tick(); n++; end
    chk("wait for out_valid", int'(ser_if.out_valid), 1);
  endtask

  initial begin
    ser_if.out_ready = 1;

    // 1: single spike at the sixth enabled edge carries timestamp 5.
    do_reset();
    ticks(5);
    pulse();
    ticks(20);
    chk_frames("t1", '{8'h05});
    chk("t1 valid cycles", vcycles, 8);
    chk("t1 spike_count", int'(count), 1);
    chk("t1 ovf_flag", int'(ovf), 0);

    // 2: spike held high counts once.
    do_reset();
    spk = 1;
    ticks(20);
    spk = 0;
    ticks(20);
    chk_frames("t2", '{8'h00});
    chk("t2 spike_count", int'(count), 1);

    // 3: stalled sink; FIFO fills, sixth event is dropped.
    do_reset();
    ser_if.out_ready = 0;
    for (int i = 0; i < 6; i++) begin pulse(); ticks(2); end
    chk("t3 fifo_level full", int'(level), 4);
    chk("t3 ovf_flag set", int'(ovf), 1);
    chk("t3 spike_count", int'(count), 6);
    ser_if.out_ready = 1;
    ticks(60);
    chk_frames("t3", '{8'd0, 8'd3, 8'd6, 8'd9, 8'd12});
    chk("t3 ovf still set", int'(ovf), 1);
    clr = 1; tick(); clr = 0;
    chk("t3 ovf cleared", int'(ovf), 0);

    // 4: timestamp wrap 255 -> 0.
    do_reset();
    wait_ts(255);
    pulse();
    ticks(2);
    pulse();
    ticks(30);
    chk_frames("t4", '{8'hFF, 8'h02});

    // 5: backpressure toggling and an enable freeze mid-frame.
    do_reset();
    wait_ts(8'hA5);
    pulse();
    wait_valid(10);
    for (int i = 0; i < 16; i++) begin
      ser_if.out_ready = (i % 2 == 0);
      if (i == 5) begin
        en = 0;
        ticks(5);
        en = 1;
      end
      tick();
    end
    ser_if.out_ready = 1;
    ticks(20);
    chk_frames("t5", '{8'hA5});
    chk("t5 spike_count", int'(count), 1);

    // 6: asynchronous reset mid-frame with three events queued.
    do_reset();
    ser_if.out_ready = 0;
    for (int i = 0; i < 4; i++) begin pulse(); ticks(2); end
    chk("t6 fifo_level before reset", int'(level), 3);
    chk("t6 out_valid before reset", int'(ser_if.out_valid), 1);
    #2;
    rst_n = 0;
    #1;
    chk("t6 async out_valid", int'(ser_if.out_valid), 0);
    chk("t6 async fifo_level", int'(level), 0);
    chk("t6 async spike_count", int'(count), 0);
    chk("t6 async ovf_flag", int'(ovf), 0);
    frames.delete();
    tick();
    rst_n = 1;
    ser_if.out_ready = 1;
    ticks(15);
    chk("t6 no frames after reset", frames.size(), 0);
    chk("t6 idle after reset", int'(ser_if.out_valid), 0);
    pulse();
    ticks(15);
    chk_frames("t6 new spike", '{8'd15});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
